feature_stream_buffer: RTL and testbench



---
 rtl/feature_stream_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_feature_stream_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_stream_buffer.sv
// -----------------------------------------------------------------------------
// feature_stream_buffer
//
// Captures deserialized row words (row 0 = initial weights, rows 1..NUM_DP =
// datapoints) into an internal store. When loading is complete, it replays
// the store as a stream of 16-bit features under a valid/ready handshake.
// The replay can be restarted for further epochs without reloading.
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_LOAD   | accepting row writes, waiting for load_done
//   S_STREAM | replaying features, out_valid high
//   S_DONE   | pass complete, waiting for restart
//   S_ERR    | bad address or incomplete load; only reset exits
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-low reset
//   we         row write strobe from the deserializer
//   addr       row address for the write
//   data_in    deserialized word, field 0 in the most significant used slot
//   load_done  deserializer finished (level)
//   restart    pulse: replay the store again from DONE
//   out_ready  consumer accepts the current feature
//   out_valid  feature available
//   out_data   feature value
//   out_row    row of the current feature
//   out_idx    field index within the row
//   out_last   current feature is the final one of the pass
//   epoch_done one-cycle pulse after the final transfer
//   err        sticky error
// -----------------------------------------------------------------------------
module feature_stream_buffer #(
    parameter int ADDR_WIDTH     = 3,
    parameter int MAX_FEATURES   = 7,
    parameter int MAX_DATA_WIDTH = 16 * (MAX_FEATURES + 1),
    parameter int NUM_DP         = 6,
    parameter int NUM_FEATURES   = 6,
    parameter int NUM_DATA_WIDTH = 16 * (NUM_FEATURES + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [MAX_DATA_WIDTH-1:0] data_in,
    input  logic                      load_done,
    input  logic                      restart,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [15:0]               out_data,
    output logic [ADDR_WIDTH-1:0]     out_row,
    output logic [3:0]                out_idx,
    output logic                      out_last,
    output logic                      epoch_done,
    output logic                      err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_DP);
    localparam logic [3:0]            LAST_IDX = 4'(NUM_FEATURES);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_DP:0]           valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]     row_q, row_d;
    logic [3:0]                idx_q, idx_d;
    logic                      err_q, err_d;
    logic                      epoch_q, epoch_d;
    logic [NUM_DATA_WIDTH-1:0] store_q [0:NUM_DP];

    logic                      addr_ok;
    logic                      store_we;
    logic                      last_beat;
    logic [NUM_DP:0]           wr_mask;
    logic [NUM_DATA_WIDTH-1:0] row_word;
    logic [15:0]               field;

    // Bits of the bus above the configured row width carry nothing.
    generate
        if (MAX_DATA_WIDTH > NUM_DATA_WIDTH) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^data_in[MAX_DATA_WIDTH-1:NUM_DATA_WIDTH];
        end
    endgenerate

    assign addr_ok   = (addr <= LAST_ROW);
    assign last_beat = (row_q == LAST_ROW) && (idx_q == LAST_IDX);

    always_comb begin
        wr_mask = '0;
        for (int r = 0; r <= NUM_DP; r++) begin
            if (addr == ADDR_WIDTH'(r)) wr_mask[r] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        row_d    = row_q;
        idx_d    = idx_q;
        err_d    = err_q;
        epoch_d  = 1'b0;
        store_we = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (we && addr_ok) begin
                    store_we = 1'b1;
                    valid_d  = valid_q | wr_mask;
                end
                if (we && !addr_ok) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (load_done) begin
                    // valid_d already includes a write landing this cycle
                    if (&valid_d) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                        epoch_d = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (restart) begin
                    row_d   = '0;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            default: begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_LOAD;
            valid_q <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            epoch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            epoch_q <= epoch_d;
        end
    end

    // Store is deliberately not reset; the valid mask forces a full reload.
    always_ff @(posedge CLK) begin
        for (int r = 0; r <= NUM_DP; r++) begin
            if (store_we && wr_mask[r]) store_q[r] <= data_in[NUM_DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        row_word = '0;
        for (int r = 0; r <= NUM_DP; r++) begin
            if (row_q == ADDR_WIDTH'(r)) row_word = store_q[r];
        end
    end

    // Field 0 is the first received, i.e. the most significant slot.
    always_comb begin
        field = '0;
        for (int k = 0; k <= NUM_FEATURES; k++) begin
            if (idx_q == 4'(k)) field = row_word[NUM_DATA_WIDTH-1-16*k -: 16];
        end
    end

    // Outputs are gated by state so that reset drives all of them to zero.
    assign out_valid  = (state_q == S_STREAM);
    assign out_data   = out_valid ? field : 16'h0000;
    assign out_row    = row_q;
    assign out_idx    = idx_q;
    assign out_last   = out_valid && last_beat;
    assign epoch_done = epoch_q;
    assign err        = err_q;

endmodule

// File: tb/tb_feature_stream_buffer.sv
module tb_feature_stream_buffer;

    localparam int AW    = 3;
    localparam int NDP   = 6;
    localparam int NF    = 6;
    localparam int MDW   = 128;
    localparam int NDW   = 112;
    localparam int TOTAL = (NDP + 1) * (NF + 1);

    logic           CLK;
    logic           RST;
    logic           we;
    logic [AW-1:0]  addr;
    logic [MDW-1:0] data_in;
    logic           load_done;
    logic           restart;
    logic           out_ready;
    logic           out_valid;
    logic [15:0]    out_data;
    logic [AW-1:0]  out_row;
    logic [3:0]     out_idx;
    logic           out_last;
    logic           epoch_done;
    logic           err;

    int checks;
    int failures;

    // Reference store: what the consumer must see, indexed [row][field].
    logic [15:0] mem_m [0:NDP][0:NF];

    feature_stream_buffer dut (
        .CLK        (CLK),
        .RST        (RST),
        .we         (we),
        .addr       (addr),
        .data_in    (data_in),
        .load_done  (load_done),
        .restart    (restart),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .epoch_done (epoch_done),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [MDW-1:0] word_of(input int r);
        logic [MDW-1:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k <= NF; k++) w[NDW-1-16*k -: 16] = mem_m[r][k];
        return w;
    endfunction

    task automatic set_pattern();
        for (int r = 0; r <= NDP; r++)
            for (int k = 0; k <= NF; k++)
                mem_m[r][k] = {r[3:0], k[3:0], 8'h00};
    endtask

    task automatic set_random();
        for (int r = 0; r <= NDP; r++)
            for (int k = 0; k <= NF; k++)
                mem_m[r][k] = 16'($urandom);
    endtask

    task automatic drive_idle();
        we        = 1'b0;
        addr      = '0;
        data_in   = '0;
        load_done = 1'b0;
        restart   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        drive_idle();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Returns at the negedge following the capturing posedge.
    task automatic write_row(input int r, input logic [MDW-1:0] w, input logic ld);
        @(negedge CLK);
        we        = 1'b1;
        addr      = r[AW-1:0];
        data_in   = w;
        load_done = ld;
        out_ready = 1'b1;
        @(negedge CLK);
        we        = 1'b0;
        load_done = 1'b0;
    endtask

    task automatic load_rows(input int first, input int last);
        for (int r = first; r <= last; r++) write_row(r, word_of(r), 1'b0);
    endtask

    // Raises load_done for one edge; returns in the first cycle after it.
    task automatic raise_load_done();
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_before_load_done: got %b want 0", out_valid);
        end
        load_done = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        load_done = 1'b0;
    endtask

    // Consumes a full pass starting in the first STREAM cycle.
    task automatic run_pass(input bit rand_ready, input int abort_at, input bit inject);
        int  b;
        int  cyc;
        int  er;
        int  ek;
        bit  rdy;
        b   = 0;
        cyc = 0;
        while (b < TOTAL && cyc < 1000) begin
            er = b / (NF + 1);
            ek = b % (NF + 1);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL valid_in_stream beat%0d: got %b want 1", b, out_valid);
            end
            checks++;
            if (out_data !== mem_m[er][ek] || out_row !== er[AW-1:0] ||
                out_idx !== ek[3:0] || out_last !== (b == TOTAL - 1)) begin
                failures++;
                $display("FAIL beat%0d: got data=%h row=%0d idx=%0d last=%b want data=%h row=%0d idx=%0d last=%b",
                         b, out_data, out_row, out_idx, out_last,
                         mem_m[er][ek], er, ek, (b == TOTAL - 1));
            end
            checks++;
            if (epoch_done !== 1'b0) begin
                failures++;
                $display("FAIL epoch_early beat%0d: got %b want 0", b, epoch_done);
            end
            rdy       = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = rdy;
            restart   = inject && (b == 10);
            we        = inject && (b == 10);
            addr      = 3'd2;
            data_in   = {$urandom, $urandom, $urandom, $urandom};
            if (rdy) b++;
            if (abort_at != 0 && b == abort_at) begin
                @(posedge CLK);
                #3;
                RST = 1'b0;
                #1;
                checks++;
                if (out_valid !== 1'b0 || err !== 1'b0 || epoch_done !== 1'b0 ||
                    out_data !== 16'h0 || out_row !== '0 || out_idx !== 4'h0 || out_last !== 1'b0) begin
                    failures++;
                    $display("FAIL async_reset: got valid=%b err=%b epoch=%b data=%h row=%0d idx=%0d last=%b want all 0",
                             out_valid, err, epoch_done, out_data, out_row, out_idx, out_last);
                end
                drive_idle();
                return;
            end
            @(negedge CLK);
            cyc++;
            restart = 1'b0;
            we      = 1'b0;
        end
        checks++;
        if (b < TOTAL) begin
            failures++;
            $display("FAIL pass_timeout: got %0d beats want %0d", b, TOTAL);
        end
        out_ready = 1'b0;
        checks++;
        if (epoch_done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL pass_end: got epoch=%b valid=%b last=%b want 1 0 0",
                     epoch_done, out_valid, out_last);
        end
        @(negedge CLK);
        checks++;
        if (epoch_done !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL epoch_pulse_width: got epoch=%b valid=%b want 0 0", epoch_done, out_valid);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        drive_idle();
        #12;
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || epoch_done !== 1'b0 ||
            out_data !== 16'h0 || out_row !== '0 || out_idx !== 4'h0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b err=%b epoch=%b data=%h row=%0d idx=%0d last=%b want all 0",
                     out_valid, err, epoch_done, out_data, out_row, out_idx, out_last);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_stream();
        set_pattern();
        load_rows(0, NDP);
        raise_load_done();
        run_pass(1'b0, 0, 1'b0);
    endtask

    task automatic test_restart();
        @(negedge CLK);
        we      = 1'b1;
        addr    = 3'd1;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge CLK);
        we      = 1'b0;
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        run_pass(1'b1, 0, 1'b1);
    endtask

    task automatic test_stall();
        apply_reset();
        set_random();
        load_rows(0, NDP);
        raise_load_done();
        run_pass(1'b1, 0, 1'b0);
    endtask

    task automatic test_duplicate();
        apply_reset();
        set_random();
        mem_m[3][0] = 16'hAAAA;
        load_rows(0, NDP);
        mem_m[3][0] = 16'hBBBB;
        // Second write of row 3 lands in the same cycle as load_done.
        write_row(3, word_of(3), 1'b1);
        run_pass(1'b0, 0, 1'b0);
    endtask

    task automatic test_missing_rows();
        apply_reset();
        set_pattern();
        load_rows(0, 4);
        raise_load_done();
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL missing_rows: got err=%b valid=%b want 1 0", err, out_valid);
        end
        load_rows(5, NDP);
        raise_load_done();
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_sticky: got err=%b valid=%b want 1 0", err, out_valid);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_reset: got %b want 0", err);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_bad_addr();
        apply_reset();
        set_pattern();
        load_rows(0, 2);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_before_bad_addr: got %b want 0", err);
        end
        write_row(7, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_addr: got err=%b valid=%b want 1 0", err, out_valid);
        end
        load_rows(3, NDP - 1);
        write_row(NDP, word_of(NDP), 1'b1);
        repeat (3) @(negedge CLK);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_addr_persist: got err=%b valid=%b want 1 0", err, out_valid);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_pattern();
        load_rows(0, NDP);
        raise_load_done();
        run_pass(1'b0, 20, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_release: got valid=%b err=%b want 0 0", out_valid, err);
        end
        set_random();
        load_rows(0, NDP);
        raise_load_done();
        run_pass(1'b1, 0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_restart();
        test_stall();
        test_duplicate();
        test_missing_rows();
        test_bad_addr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
